gps_display_select: RTL

//  Parametrised display-source selector between the GPS data producers (lat/lon/speed/etc.) and the 7-seg driver.

---
 rtl/gps_display_select_if.sv | 28 ++
 rtl/gps_display_select.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/gps_display_select_if.sv
// Bundle between the GPS digit producers / selection switches and the display selector.
// master = producer/switch side, slave = the selector.
interface gps_display_select_if #(
  parameter int NUM_SRC = 4,
  parameter int NUM_DIG = 4
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC*NUM_DIG*4-1:0] src_digits;
  logic [NUM_SRC-1:0]           src_valid;
  logic [NUM_SRC-1:0]           sel;
  logic                         auto_en;
  logic [NUM_DIG*4-1:0]         disp_digits;
  logic [NUM_DIG-1:0]           disp_blank;
  logic [SRC_W-1:0]             cur_src;
  logic                         disp_stale;
  logic                         disp_update;

  modport master (
    output src_digits, src_valid, sel, auto_en,
    input  disp_digits, disp_blank, cur_src, disp_stale, disp_update
  );

  modport slave (
    input  src_digits, src_valid, sel, auto_en,
    output disp_digits, disp_blank, cur_src, disp_stale, disp_update
  );
endinterface

// File: rtl/gps_display_select.sv
// Display-source selector: per-source BCD snapshots with staleness tracking, manual or
// timed auto-rotating selection, and one registered tear-free digit set with blanking.
module gps_display_select #(
  parameter int          NUM_SRC      = 4,
  parameter int          NUM_DIG      = 4,
  parameter int unsigned DWELL_CYCLES = 300000000,
  parameter int unsigned STALE_CYCLES = 200000000,
  parameter logic [3:0]  DASH_CODE    = 4'hA,
  parameter bit          LZB_EN       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  gps_display_select_if.slave  bus
);
  localparam int          SRC_W   = $clog2(NUM_SRC);
  localparam int          DISP_W  = NUM_DIG * 4;
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > STALE_CYCLES) ? DWELL_CYCLES : STALE_CYCLES;
  localparam int          CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] STALE_MAX  = CNT_W'(STALE_CYCLES);
  localparam logic [SRC_W-1:0] SRC_LAST   = SRC_W'(NUM_SRC - 1);

  localparam logic [1:0] ST_MANUAL = 2'd0;
  localparam logic [1:0] ST_AUTO   = 2'd1;
  localparam logic [1:0] ST_IDLE   = 2'd2;

  logic [DISP_W-1:0] snap_q      [NUM_SRC];
  logic [DISP_W-1:0] snap_d      [NUM_SRC];
  logic [CNT_W-1:0]  stale_cnt_q [NUM_SRC];
  logic [CNT_W-1:0]  stale_cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] stale_q, stale_d;

  logic [1:0]        state;
  logic [SRC_W-1:0]  low_idx;
  logic [SRC_W-1:0]  cur_src_q, cur_src_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;

  logic [DISP_W-1:0]  sel_digits;
  logic               zero_above;
  logic [DISP_W-1:0]  disp_digits_q, disp_digits_d;
  logic [NUM_DIG-1:0] disp_blank_q, disp_blank_d;
  logic               disp_stale_q, disp_stale_d;
  logic               disp_update_q, disp_update_d;

  // Snapshot capture and staleness; a strobe in the threshold cycle keeps the source fresh.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      snap_d[s]      = snap_q[s];
      stale_cnt_d[s] = stale_cnt_q[s];
      stale_d[s]     = stale_q[s];
      if (bus.src_valid[s]) begin
        snap_d[s]      = bus.src_digits[s*DISP_W +: DISP_W];
        stale_cnt_d[s] = '0;
        stale_d[s]     = 1'b0;
      end else if (stale_cnt_q[s] != STALE_MAX) begin
        stale_cnt_d[s] = stale_cnt_q[s] + CNT_W'(1);
        if (stale_cnt_d[s] == STALE_MAX) stale_d[s] = 1'b1;
      end
    end
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.sel[i]) low_idx = SRC_W'(i);
    end
  end

  always_comb begin
    if (|bus.sel)        state = ST_MANUAL;
    else if (bus.auto_en) state = ST_AUTO;
    else                 state = ST_IDLE;
  end

  // The dwell counter only runs in AUTO, so entering AUTO always starts a full dwell.
  always_comb begin
    cur_src_d = cur_src_q;
    dwell_d   = '0;
    case (state)
      ST_MANUAL: cur_src_d = low_idx;
      ST_AUTO: begin
        if (dwell_q == DWELL_LAST) begin
          cur_src_d = (cur_src_q == SRC_LAST) ? '0 : cur_src_q + SRC_W'(1);
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      default: cur_src_d = '0;
    endcase
  end

  always_comb begin
    sel_digits    = snap_q[cur_src_q];
    zero_above    = 1'b1;
    disp_blank_d  = '0;
    disp_digits_d = sel_digits;
    disp_stale_d  = 1'b0;
    if (stale_q[cur_src_q]) begin
      disp_digits_d = {NUM_DIG{DASH_CODE}};
      disp_stale_d  = 1'b1;
    end else begin
      for (int d = NUM_DIG - 1; d >= 1; d--) begin
        zero_above      = zero_above & (sel_digits[d*4 +: 4] == 4'd0);
        disp_blank_d[d] = LZB_EN & zero_above;
      end
    end
    disp_update_d = (disp_digits_d != disp_digits_q) || (disp_blank_d != disp_blank_q) ||
                    (disp_stale_d != disp_stale_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        snap_q[s]      <= '0;
        stale_cnt_q[s] <= '0;
      end
      stale_q       <= '1;
      cur_src_q     <= '0;
      dwell_q       <= '0;
      disp_digits_q <= {NUM_DIG{DASH_CODE}};
      disp_blank_q  <= '0;
      disp_stale_q  <= 1'b1;
      disp_update_q <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SRC; s++) begin
        snap_q[s]      <= snap_d[s];
        stale_cnt_q[s] <= stale_cnt_d[s];
      end
      stale_q       <= stale_d;
      cur_src_q     <= cur_src_d;
      dwell_q       <= dwell_d;
      disp_digits_q <= disp_digits_d;
      disp_blank_q  <= disp_blank_d;
      disp_stale_q  <= disp_stale_d;
      disp_update_q <= disp_update_d;
    end
  end

  assign bus.disp_digits = disp_digits_q;
  assign bus.disp_blank  = disp_blank_q;
  assign bus.cur_src     = cur_src_q;
  assign bus.disp_stale  = disp_stale_q;
  assign bus.disp_update = disp_update_q;
endmodule
